// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision FP adder datapath.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  // Biased exponent value reserved for Inf/NaN.
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,  // round to nearest, ties to even
    RM_RTZ = 2'd1,  // round toward zero
    RM_RUP = 2'd2,  // round toward +inf
    RM_RDN = 2'd3   // round toward -inf
  } rmode_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // True when the biased exponent encodes Inf or NaN.
  function automatic logic is_inf_nan(input logic [EXP_W-1:0] exp);
    return (exp == EXP_MAX);
  endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Combinational rounding decision: whether to add one ulp to the
// truncated fraction, given sign, LSB, guard/round/sticky and mode.
module fp_round_decide
  import fp_pkg::*;
(
  input  logic   sign,
  input  logic   lsb,
  input  logic   guard,
  input  logic   round_bit,
  input  logic   sticky,
  input  rmode_t rmode,
  output logic   inc
);

  logic any_s;

  assign any_s = guard | round_bit | sticky;

  // Select the increment rule for the requested rounding mode.
  always_comb begin
    inc = 1'b0;
    case (rmode)
      RM_RNE:  inc = guard & (lsb | round_bit | sticky);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign & any_s;
      RM_RDN:  inc = sign & any_s;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_round_pack.sv
// Round-and-pack stage of the FP adder. Stage 1 captures the normalized
// operand and decides the rounding increment; stage 2 applies it, handles
// mantissa carry into the exponent and overflow, and drives the packed
// result. Both stages form a valid/ready pipeline with full backpressure.
module fp_round_pack #(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int FRAC_W = fp_pkg::FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [FRAC_W-1:0]       in_frac,
  input  logic [2:0]              in_grs,
  input  logic [1:0]              rmode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic                    out_inexact,
  output logic                    out_overflow
);

  import fp_pkg::*;

  localparam int                 RES_W   = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W-1:0]   EXP_TOP = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]   EXP_FIN = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [FRAC_W-1:0]  FRAC_0  = {FRAC_W{1'b0}};
  localparam logic [FRAC_W-1:0]  FRAC_1S = {FRAC_W{1'b1}};

  // Handshake
  logic adv1_s;
  logic adv2_s;

  // Stage 1 registers
  logic               s1_valid_q,   s1_valid_d;
  logic               s1_sign_q,    s1_sign_d;
  logic [EXP_W-1:0]   s1_exp_q,     s1_exp_d;
  logic [FRAC_W-1:0]  s1_frac_q,    s1_frac_d;
  rmode_t             s1_rmode_q,   s1_rmode_d;
  logic               s1_inc_q,     s1_inc_d;
  logic               s1_inexact_q, s1_inexact_d;

  // Stage 2 registers (drive the outputs directly)
  logic               s2_valid_q,    s2_valid_d;
  logic [RES_W-1:0]   s2_result_q,   s2_result_d;
  logic               s2_inexact_q,  s2_inexact_d;
  logic               s2_overflow_q, s2_overflow_d;

  // Stage 1 combinational
  rmode_t             in_rmode_s;
  logic               in_special_s;
  logic               round_inc_s;

  // Stage 2 combinational
  logic [FRAC_W:0]    sum_s;
  logic [EXP_W-1:0]   exp_rnd_s;
  logic               s1_special_s;
  logic               at_max_s;
  logic               ovf_s;
  logic               to_inf_s;
  logic [RES_W-1:0]   result_s;

  // A stage may advance when it is empty or its consumer is advancing;
  // in_ready is a pure combinational function of out_ready and the flags.
  assign adv2_s   = ~s2_valid_q | out_ready;
  assign adv1_s   = ~s1_valid_q | adv2_s;
  assign in_ready = adv1_s;

  assign in_rmode_s   = rmode_t'(rmode);
  assign in_special_s = is_inf_nan(in_exp);

  fp_round_decide u_round_decide (
    .sign      (in_sign),
    .lsb       (in_frac[0]),
    .guard     (in_grs[2]),
    .round_bit (in_grs[1]),
    .sticky    (in_grs[0]),
    .rmode     (in_rmode_s),
    .inc       (round_inc_s)
  );

  // Stage 1 next state: capture the beat and its rounding decision.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_exp_d     = s1_exp_q;
    s1_frac_d    = s1_frac_q;
    s1_rmode_d   = s1_rmode_q;
    s1_inc_d     = s1_inc_q;
    s1_inexact_d = s1_inexact_q;
    if (adv1_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d    = in_sign;
        s1_exp_d     = in_exp;
        s1_frac_d    = in_frac;
        s1_rmode_d   = in_rmode_s;
        // Inf/NaN pass through untouched and are never inexact.
        s1_inc_d     = in_special_s ? 1'b0 : round_inc_s;
        s1_inexact_d = in_special_s ? 1'b0 : (|in_grs);
      end else begin
        s1_sign_d = s1_sign_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 1 state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= {EXP_W{1'b0}};
      s1_frac_q    <= {FRAC_W{1'b0}};
      s1_rmode_q   <= RM_RNE;
      s1_inc_q     <= 1'b0;
      s1_inexact_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_frac_q    <= s1_frac_d;
      s1_rmode_q   <= s1_rmode_d;
      s1_inc_q     <= s1_inc_d;
      s1_inexact_q <= s1_inexact_d;
    end
  end

  // Apply the increment; a carry out of the fraction leaves it zero and
  // bumps the exponent (this also turns a denormal into exponent 1).
  assign sum_s     = {1'b0, s1_frac_q} + {{FRAC_W{1'b0}}, s1_inc_q};
  assign exp_rnd_s = s1_exp_q + {{(EXP_W-1){1'b0}}, sum_s[FRAC_W]};

  // Overflow: operand is the largest finite magnitude and the exact value
  // lies above it. For RNE that is exactly when rounding carries into the
  // all-ones exponent; for the directed modes any discarded bits count,
  // and the mode then decides between infinity and saturation.
  assign s1_special_s = is_inf_nan(s1_exp_q);
  assign at_max_s     = (s1_exp_q == EXP_FIN) && (s1_frac_q == FRAC_1S);
  assign ovf_s        = ~s1_special_s & at_max_s &
                        ((s1_rmode_q == RM_RNE) ? s1_inc_q : s1_inexact_q);

  // Decide whether an overflowing result rounds to infinity.
  always_comb begin
    to_inf_s = 1'b0;
    case (s1_rmode_q)
      RM_RNE:  to_inf_s = 1'b1;
      RM_RTZ:  to_inf_s = 1'b0;
      RM_RUP:  to_inf_s = ~s1_sign_q;
      RM_RDN:  to_inf_s = s1_sign_q;
      default: to_inf_s = 1'b0;
    endcase
  end

  // Assemble the packed result.
  always_comb begin
    result_s = {s1_sign_q, exp_rnd_s, sum_s[FRAC_W-1:0]};
    if (ovf_s) begin
      if (to_inf_s) begin
        result_s = {s1_sign_q, EXP_TOP, FRAC_0};
      end else begin
        result_s = {s1_sign_q, EXP_FIN, FRAC_1S};
      end
    end else begin
      result_s = {s1_sign_q, exp_rnd_s, sum_s[FRAC_W-1:0]};
    end
  end

  // Stage 2 next state: take stage 1's beat when the output may advance.
  always_comb begin
    s2_valid_d    = s2_valid_q;
    s2_result_d   = s2_result_q;
    s2_inexact_d  = s2_inexact_q;
    s2_overflow_d = s2_overflow_q;
    if (adv2_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d   = result_s;
        s2_inexact_d  = s1_inexact_q;
        s2_overflow_d = ovf_s;
      end else begin
        s2_result_d = s2_result_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Stage 2 state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q    <= 1'b0;
      s2_result_q   <= {RES_W{1'b0}};
      s2_inexact_q  <= 1'b0;
      s2_overflow_q <= 1'b0;
    end else begin
      s2_valid_q    <= s2_valid_d;
      s2_result_q   <= s2_result_d;
      s2_inexact_q  <= s2_inexact_d;
      s2_overflow_q <= s2_overflow_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_result   = s2_result_q;
  assign out_inexact  = s2_inexact_q;
  assign out_overflow = s2_overflow_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Scoreboard bench for fp_round_pack: directed cases, backpressure,
// mid-flight reset, randomized traffic, and an exhaustive check of the
// rounding-decision sub-module.
module tb_fp_round_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_frac;
  logic [2:0]  in_grs;
  logic [1:0]  rmode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_inexact;
  logic        out_overflow;

  typedef struct {
    logic [31:0] res;
    logic        inx;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t ovr_val;
  bit   ovr_en = 1'b0;
  bit   rand_ready_en = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // Stand-alone rounding decision unit
  logic        ud_sign, ud_lsb, ud_g, ud_r, ud_s, ud_inc;
  logic [1:0]  ud_rm;

  always #5 clk = ~clk;

  fp_round_pack dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_frac      (in_frac),
    .in_grs       (in_grs),
    .rmode        (rmode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_inexact  (out_inexact),
    .out_overflow (out_overflow)
  );

  fp_round_decide u_dec (
    .sign      (ud_sign),
    .lsb       (ud_lsb),
    .guard     (ud_g),
    .round_bit (ud_r),
    .sticky    (ud_s),
    .rmode     (fp_pkg::rmode_t'(ud_rm)),
    .inc       (ud_inc)
  );

  // Round-up decision from the value view: the discarded tail grs is a
  // fraction of one ulp in eighths (4 = exactly half).
  function automatic bit ref_up(input bit s, input bit odd, input int tail, input int rm);
    bit up;
    case (rm)
      0:       up = (tail > 4) || (tail == 4 && odd);
      1:       up = 1'b0;
      2:       up = (tail != 0) && !s;
      default: up = (tail != 0) && s;
    endcase
    return up;
  endfunction

  // Reference: treat {exp,frac} as an unsigned magnitude code, round it,
  // and compare against the largest finite code 0x7F7FFFFF.
  function automatic exp_t ref_model(input bit s, input logic [7:0] e, input logic [22:0] f,
                                     input logic [2:0] grs, input logic [1:0] rm);
    exp_t r;
    int unsigned mag, rounded;
    int unsigned maxf = 32'h7F7F_FFFF;
    bit inx, up, ovf, to_inf;
    if (e == 8'hFF) begin
      r.res = {s, e, f};
      r.inx = 1'b0;
      r.ovf = 1'b0;
      return r;
    end
    mag     = {1'b0, e, f};
    inx     = (grs != 3'd0);
    up      = ref_up(s, f[0], int'(grs), int'(rm));
    rounded = mag + (up ? 32'd1 : 32'd0);
    ovf     = (rm == 2'd0) ? (rounded > maxf) : (mag == maxf && inx);
    to_inf  = (rm == 2'd0) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
    if (ovf) r.res = to_inf ? {s, 31'h7F80_0000} : {s, 31'h7F7F_FFFF};
    else     r.res = {s, rounded[30:0]};
    r.inx = inx;
    r.ovf = ovf;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  // Monitor: on the falling edge, record accepted beats and check
  // delivered results; both transfers complete at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_out: got %h with empty scoreboard, required no output", out_result);
        end else begin
          mon_e = sb.pop_front();
          if (out_result !== mon_e.res || out_inexact !== mon_e.inx || out_overflow !== mon_e.ovf) begin
            miscompares++;
            $display("FAIL result: got %h inx=%b ovf=%b, required %h inx=%b ovf=%b",
                     out_result, out_inexact, out_overflow, mon_e.res, mon_e.inx, mon_e.ovf);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (ovr_en) sb.push_back(ovr_val);
        else        sb.push_back(ref_model(in_sign, in_exp, in_frac, in_grs, rmode));
      end
    end
  end

  task automatic upd_ready();
    if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      upd_ready();
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input bit s, input logic [7:0] e, input logic [22:0] f,
                      input logic [2:0] grs, input logic [1:0] rm,
                      input bit ov, input logic [31:0] ores, input bit oinx, input bit oovf);
    int n = 0;
    in_sign = s; in_exp = e; in_frac = f; in_grs = grs; rmode = rm;
    ovr_en = ov; ovr_val.res = ores; ovr_val.inx = oinx; ovr_val.ovf = oovf;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        vectors++; miscompares++;
        $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        break;
      end
      @(posedge clk); #1;
      upd_ready();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    ovr_en = 1'b0;
    upd_ready();
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  e;
    logic [22:0] f;
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'h00;
    in_frac = 23'h0; in_grs = 3'b000; rmode = 2'd0; out_ready = 1'b1;

    // Exhaustive rounding-decision unit check
    for (int i = 0; i < 64; i++) begin
      {ud_sign, ud_lsb, ud_g, ud_r, ud_s, ud_rm} = 7'(i << 1) >> 1;
      ud_sign = i[5]; ud_lsb = i[4]; ud_g = i[3]; ud_r = i[2]; ud_s = i[1];
      ud_rm = {i[0], ud_g ^ i[0]};
      #1;
      chk("round_decide", {31'd0, ud_inc},
          {31'd0, ref_up(ud_sign, ud_lsb, int'({ud_g, ud_r, ud_s}), int'(ud_rm))});
    end
    for (int i = 0; i < 32; i++) begin
      ud_sign = i[4]; ud_lsb = i[3]; ud_g = i[2]; ud_r = i[1]; ud_s = i[0];
      for (int m = 0; m < 4; m++) begin
        ud_rm = 2'(m);
        #1;
        chk("round_decide", {31'd0, ud_inc},
            {31'd0, ref_up(ud_sign, ud_lsb, int'({ud_g, ud_r, ud_s}), m)});
      end
    end

    // Reset state
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_flags", {30'd0, out_inexact, out_overflow}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Directed cases with hand-computed expectations
    send(1'b0, 8'h7F, 23'h000000, 3'b100, 2'd0, 1'b1, 32'h3F80_0000, 1'b1, 1'b0);
    send(1'b0, 8'h7F, 23'h000001, 3'b100, 2'd0, 1'b1, 32'h3F80_0002, 1'b1, 1'b0);
    send(1'b0, 8'h7F, 23'h000001, 3'b100, 2'd1, 1'b1, 32'h3F80_0001, 1'b1, 1'b0);
    send(1'b0, 8'hFE, 23'h7FFFFF, 3'b110, 2'd0, 1'b1, 32'h7F80_0000, 1'b1, 1'b1);
    send(1'b0, 8'hFE, 23'h7FFFFF, 3'b110, 2'd1, 1'b1, 32'h7F7F_FFFF, 1'b1, 1'b1);
    send(1'b0, 8'hFE, 23'h7FFFFF, 3'b110, 2'd3, 1'b1, 32'h7F7F_FFFF, 1'b1, 1'b1);
    send(1'b0, 8'h7F, 23'h7FFFFF, 3'b100, 2'd0, 1'b1, 32'h4000_0000, 1'b1, 1'b0);
    send(1'b1, 8'h7F, 23'h7FFFFF, 3'b001, 2'd3, 1'b1, 32'hC000_0000, 1'b1, 1'b0);
    send(1'b0, 8'hFF, 23'h400000, 3'b111, 2'd0, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0);
    send(1'b1, 8'h00, 23'h000000, 3'b000, 2'd0, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
    send(1'b0, 8'h00, 23'h7FFFFF, 3'b111, 2'd2, 1'b1, 32'h0080_0000, 1'b1, 1'b0);
    send(1'b1, 8'hFE, 23'h7FFFFF, 3'b001, 2'd2, 1'b1, 32'hFF7F_FFFF, 1'b1, 1'b1);
    drain();

    // Backpressure: two beats fill the pipe, then in_ready must drop
    out_ready = 1'b0;
    fork
      begin
        send(1'b0, 8'h10, 23'h000011, 3'b000, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        send(1'b1, 8'h20, 23'h000022, 3'b101, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        send(1'b0, 8'h30, 23'h000033, 3'b011, 2'd2, 1'b0, 32'd0, 1'b0, 1'b0);
        send(1'b1, 8'h40, 23'h000044, 3'b111, 2'd3, 1'b0, 32'd0, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        repeat (2) @(negedge clk);
        chk("bp_hold_count", sb.size(), 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two beats in flight
    send(1'b0, 8'h55, 23'h012345, 3'b010, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    send(1'b1, 8'h66, 23'h054321, 3'b110, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(6);
    chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);

    // Randomized traffic with random backpressure
    rand_ready_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: e = 8'hFF;
        1: e = 8'hFE;
        2: e = 8'h00;
        3: e = 8'h7F;
        default: e = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: f = 23'h7FFFFF;
        1: f = 23'h000000;
        2: f = 23'h7FFFFE;
        default: f = 23'($urandom);
      endcase
      send(1'($urandom), e, f, 3'($urandom), 2'($urandom), 1'b0, 32'd0, 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_ready_en = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
